// File: rtl/imbuf_pingpong_if.sv
// imbuf_pingpong_if: frame length, write stream and read stream of the ping-pong buffer.
// IMBUF_FLIP_EN adds the per-frame i_flip request.
interface imbuf_pingpong_if #(
    parameter int D_BITS = 8,
    parameter int LEN_W  = 32
);
    logic [LEN_W-1:0]  i_len;
    logic [D_BITS-1:0] i_data;
    logic              i_valid;
    logic              o_ready;
    logic [D_BITS-1:0] o_data;
    logic              o_valid;
    logic              o_last;
    logic              i_ready;
    logic [1:0]        o_full_cnt;
    logic              o_err;
`ifdef IMBUF_FLIP_EN
    logic              i_flip;

    modport master (
        output i_len, i_data, i_valid, i_ready, i_flip,
        input  o_ready, o_data, o_valid, o_last, o_full_cnt, o_err
    );
    modport slave (
        input  i_len, i_data, i_valid, i_ready, i_flip,
        output o_ready, o_data, o_valid, o_last, o_full_cnt, o_err
    );
`else
    modport master (
        output i_len, i_data, i_valid, i_ready,
        input  o_ready, o_data, o_valid, o_last, o_full_cnt, o_err
    );
    modport slave (
        input  i_len, i_data, i_valid, i_ready,
        output o_ready, o_data, o_valid, o_last, o_full_cnt, o_err
    );
`endif
endinterface

// File: rtl/imbuf_pingpong.sv
// imbuf_pingpong: two-bank frame buffer, one bank fills while the other streams out.
// IMBUF_FLIP_EN: per-frame i_flip selects descending readout.
module imbuf_pingpong #(
    parameter int D_BITS = 8,
    parameter int N      = 400,
    parameter int LEN_W  = 32
) (
    input  logic              i_clk,
    input  logic              reset_n,
    imbuf_pingpong_if.slave   bus
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic {W_IDLE, W_FILL}   w_state_t;
    typedef enum logic {R_IDLE, R_STREAM} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [D_BITS-1:0] mem [2][N];
    logic [CW-1:0]     blen [2];
    logic [1:0]        full;
    logic              wbank, rbank;
    logic [AW-1:0]     waddr, raddr;
    logic [CW-1:0]     wlen, rcnt, rlen, len_sat;
    logic              ready_q, valid_q, last_q, err_q;
    logic [D_BITS-1:0] data_q;
    logic [1:0]        cnt_q;
    logic              len_zero, len_big, w_start, w_hs, w_done;
    logic              rd_en, r_fire, r_done, more, rflip;

`ifdef IMBUF_FLIP_EN
    logic       wflip;
    logic [1:0] bflip;
    assign rflip = bflip[rbank];
`else
    assign rflip = 1'b0;
`endif

    assign len_zero = bus.i_len == '0;
    assign len_big  = bus.i_len > LEN_W'(N);
    assign len_sat  = len_big ? CW'(N) : bus.i_len[CW-1:0];
    assign w_start  = (w_state == W_IDLE) && !len_zero && !full[wbank];
    assign w_hs     = bus.i_valid && ready_q;
    assign w_done   = w_hs && (waddr == AW'(wlen - CW'(1)));

    assign rlen   = blen[rbank];
    assign more   = rcnt < rlen;
    assign raddr  = rflip ? AW'(rlen - CW'(1) - rcnt) : AW'(rcnt);
    assign r_fire = valid_q && bus.i_ready;
    assign r_done = r_fire && last_q;

    always_comb begin
        w_next = w_state;
        r_next = r_state;
        rd_en  = 1'b0;
        unique case (w_state)
            W_IDLE: if (w_start) w_next = W_FILL;
            W_FILL: if (w_done)  w_next = W_IDLE;
        endcase
        unique case (r_state)
            R_IDLE: begin
                if (full[rbank]) begin
                    rd_en  = 1'b1;
                    r_next = R_STREAM;
                end
            end
            R_STREAM: begin
                // next read issued as the current word leaves
                rd_en = more && (!valid_q || bus.i_ready);
                if (r_done) r_next = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_hs) mem[wbank][waddr] <= bus.i_data;
    end

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            full    <= '0;
            blen[0] <= '0;
            blen[1] <= '0;
            wbank   <= 1'b0;
            rbank   <= 1'b0;
            waddr   <= '0;
            wlen    <= '0;
            rcnt    <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef IMBUF_FLIP_EN
            wflip   <= 1'b0;
            bflip   <= '0;
`endif
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            ready_q <= w_next == W_FILL;
            if (w_start) begin
                wlen  <= len_sat;
                waddr <= '0;
`ifdef IMBUF_FLIP_EN
                wflip <= bus.i_flip;
`endif
            end else if (w_hs) begin
                waddr <= waddr + AW'(1);
            end
            if (w_state == W_IDLE && (len_zero || (w_start && len_big)))
                err_q <= 1'b1;
            if (w_done) begin
                full[wbank] <= 1'b1;
                blen[wbank] <= wlen;
                wbank       <= !wbank;
`ifdef IMBUF_FLIP_EN
                bflip[wbank] <= wflip;
`endif
            end
            if (r_done) begin
                full[rbank] <= 1'b0;
                rbank       <= !rbank;
                rcnt        <= '0;
            end
            if (rd_en) begin
                data_q  <= mem[rbank][raddr];
                last_q  <= rcnt == rlen - CW'(1);
                valid_q <= 1'b1;
                rcnt    <= rcnt + CW'(1);
            end else if (r_fire) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
            unique case ({w_done, r_done})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign bus.o_ready    = ready_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_last     = last_q;
    assign bus.o_data     = data_q;
    assign bus.o_err      = err_q;
    assign bus.o_full_cnt = cnt_q;
endmodule

// File: tb/tb_imbuf_pingpong.sv
// tb_imbuf_pingpong: random frames through the ping-pong buffer, checked by a
// frame-level scoreboard fed by the writer and drained by an output monitor.
module tb_imbuf_pingpong;
    localparam int D  = 8;
    localparam int N  = 16;
    localparam int LW = 32;
`ifdef IMBUF_FLIP_EN
    localparam bit FLIP_EN = 1'b1;
`else
    localparam bit FLIP_EN = 1'b0;
`endif

    logic i_clk   = 1'b0;
    logic reset_n = 1'b0;

    imbuf_pingpong_if #(.D_BITS(D), .LEN_W(LW)) ifc ();

    imbuf_pingpong #(.D_BITS(D), .N(N), .LEN_W(LW)) dut (
        .i_clk   (i_clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fw = 0;
    int fr = 0;
    int rdy_mode = 0;
    int last_wr_cyc = 0;
    bit lat_arm = 1'b0;
    bit cur_flip = 1'b0;
    logic [D:0] exp_q[$];

    task automatic chk(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic set_next(input int nlen, input bit nflip);
        ifc.i_len = nlen;
        cur_flip  = nflip;
`ifdef IMBUF_FLIP_EN
        ifc.i_flip = nflip;
`endif
    endtask

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    // downstream sink: always ready, random, or stalled
    initial begin
        ifc.i_ready = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            case (rdy_mode)
                0:       ifc.i_ready = 1'b1;
                1:       ifc.i_ready = 1'($urandom_range(0, 1));
                default: ifc.i_ready = 1'b0;
            endcase
        end
    end

    initial begin
        bit pstall = 1'b0;
        logic [D-1:0] pd = '0;
        logic pl = 1'b0;
        logic [D:0] e;
        forever begin
            @(negedge i_clk);
            if (!reset_n) begin
                pstall = 1'b0;
            end else begin
                chk("full_cnt", int'(ifc.o_full_cnt), fw - fr);
                tests++;
                if (ifc.o_ready && (fw - fr) == 2) begin
                    fails++;
                    $display("FAIL ready_when_full: got o_ready=1 want 0");
                end
                if (pstall) begin
                    tests++;
                    if (!ifc.o_valid || ifc.o_data != pd || ifc.o_last != pl) begin
                        fails++;
                        $display("FAIL stall_hold: got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                                 ifc.o_valid, ifc.o_data, ifc.o_last, pd, pl);
                    end
                end
                if (lat_arm && ifc.o_valid) begin
                    lat_arm = 1'b0;
                    chk("latency", cyc - last_wr_cyc, 2);
                end
                if (ifc.o_valid && ifc.i_ready) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_word: got %h want none", ifc.o_data);
                    end else begin
                        e = exp_q.pop_front();
                        if ({ifc.o_last, ifc.o_data} != e) begin
                            fails++;
                            $display("FAIL data: got last=%0b %h want last=%0b %h",
                                     ifc.o_last, ifc.o_data, e[D], e[D-1:0]);
                        end
                        if (e[D]) fr++;
                    end
                end
                pstall = ifc.o_valid && !ifc.i_ready;
                pd = ifc.o_data;
                pl = ifc.o_last;
            end
        end
    end

    task automatic wr_word(input logic [D-1:0] d);
        int t = 0;
        bit hs = 1'b0;
        while (!hs && t < 400) begin
            ifc.i_valid = ($urandom_range(0, 3) != 0);
            ifc.i_data  = d;
            @(negedge i_clk);
            hs = ifc.i_valid && ifc.o_ready;
            if (hs) last_wr_cyc = cyc;
            @(posedge i_clk);
            #1;
            t++;
        end
        ifc.i_valid = 1'b0;
        if (!hs) begin
            tests++;
            fails++;
            $display("FAIL wr_timeout: got no handshake want accept of %h", d);
        end
    endtask

    // frame length/flip were already presented; the writer may only accept min(len, N)
    task automatic send_frame(input int len, input int base, input int nlen, input bit nflip);
        int eff = (len > N) ? N : len;
        bit fflip = cur_flip;
        logic [D-1:0] f[$];
        logic [D-1:0] d;
        for (int i = 0; i < eff; i++) begin
            d = (base < 0) ? D'($urandom) : D'(base + i);
            wr_word(d);
            f.push_back(d);
        end
        set_next(nlen, nflip);
        fw++;
        for (int k = 0; k < eff; k++)
            exp_q.push_back({k == eff - 1, (FLIP_EN && fflip) ? f[eff-1-k] : f[k]});
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || fw != fr) && t < 3000) begin
            @(posedge i_clk);
            t++;
        end
        #1;
        if (exp_q.size() != 0 || fw != fr) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d words left want 0", exp_q.size());
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, int'(ifc.o_valid), 0);
        chk({tag, "_ready"}, int'(ifc.o_ready), 0);
        chk({tag, "_last"}, int'(ifc.o_last), 0);
        chk({tag, "_data"}, int'(ifc.o_data), 0);
        chk({tag, "_cnt"}, int'(ifc.o_full_cnt), 0);
        chk({tag, "_err"}, int'(ifc.o_err), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        fw = 0;
        fr = 0;
        exp_q.delete();
        repeat (2) @(posedge i_clk);
        #1;
        check_zero("rst");
        @(negedge i_clk);
        reset_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int lens[10];
        bit flips[10];
        bit seen;
        ifc.i_data  = '0;
        ifc.i_valid = 1'b0;
        set_next(5, 1'b0);
        do_reset();

        lat_arm  = 1'b1;
        rdy_mode = 0;
        send_frame(5, 'h11, 4, 1'b0);
        send_frame(4, -1, 4, 1'b0);
        send_frame(4, -1, 3, 1'b0);
        wait_drain();

        rdy_mode = 2;
        send_frame(3, -1, 3, 1'b0);
        send_frame(3, -1, 3, 1'b0);
        repeat (6) @(posedge i_clk);
        #1;
        chk("bp_full_cnt", int'(ifc.o_full_cnt), 2);
        chk("bp_ready", int'(ifc.o_ready), 0);
        chk("err_clean", int'(ifc.o_err), 0);
        rdy_mode = 0;
        send_frame(3, -1, N + 10, 1'b0);
        send_frame(N + 10, -1, 2, 1'b0);
        wait_drain();
        chk("err_oversize", int'(ifc.o_err), 1);

        set_next(5, 1'b0);
        do_reset();
        rdy_mode = 1;
        wr_word(8'h21);
        wr_word(8'h22);
        reset_n = 1'b0;
        fw = 0;
        fr = 0;
        exp_q.delete();
        #1;
        check_zero("midrst");
        set_next(2, 1'b0);
        repeat (2) @(negedge i_clk);
        reset_n = 1'b1;
        @(posedge i_clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            lens[i]  = $urandom_range(1, N);
            flips[i] = 1'($urandom_range(0, 1));
        end
        send_frame(2, -1, lens[0], flips[0]);
        for (int i = 0; i < 10; i++) begin
            rdy_mode = $urandom_range(0, 1);
            if (i == 9) send_frame(lens[i], -1, 3, 1'b1);
            else        send_frame(lens[i], -1, lens[i+1], flips[i+1]);
        end
        rdy_mode = 1;
        send_frame(3, 'hA, 0, 1'b0);
        wait_drain();
        chk("err_zero_len", int'(ifc.o_err), 1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge i_clk);
            seen = seen | ifc.o_ready;
        end
        chk("no_ready_len0", int'(seen), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/imbuf_pingpong.md
Name: imbuf_pingpong

Overview:
- Parametrised successor to the single-bank image byte buffer.
- Two N-deep banks: a frame of i_len words is written into one bank while the previously completed frame streams out of the other.
- Both sides use valid/ready handshakes; no tri-state output.
- Sits between the UART/stream receiver and the image filter/transmitter.

Parameters:
D_BITS, 8, data word width
N, 400, words per bank (max frame length)
LEN_W, 32, width of the frame-length input

Ports:
i_clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
i_len  in  LEN_W  frame length in words, sampled at frame start
i_data  in  D_BITS  write data
i_valid  in  1  write data valid
o_ready  out  1  write side can accept (handshake = i_valid & o_ready)
o_data  out  D_BITS  read data
o_valid  out  1  read data valid
o_last  out  1  marks last word of frame, qualified by o_valid
i_ready  in  1  downstream accepts (handshake = o_valid & i_ready)
o_full_cnt  out  2  banks holding complete, unsent frames (0..2)
o_err  out  1  sticky: a frame length of 0 or >N was seen

Behaviour:
- Reset (async assert, sync release): all outputs 0; both banks empty; write and read bank pointers = 0; FSMs in W_IDLE and R_IDLE.
- Write FSM:
  - W_IDLE: if i_len != 0 and the target bank is empty, latch the length and go to W_FILL.
    - Latched length = min(i_len, N). If i_len > N, set o_err.
    - If i_len == 0, stay in W_IDLE and set o_err.
  - W_FILL: o_ready = 1. Each handshake writes bank[wbank][waddr] and increments waddr.
  - On the handshake with waddr == len-1: mark the bank full and store its length, toggle wbank, go to W_IDLE. o_ready drops the following cycle.
  - o_ready is registered. It is never high while the target bank is full.
- Read FSM:
  - R_IDLE: when bank[rbank] is full, issue a synchronous RAM read of addr 0 and go to R_STREAM.
  - R_STREAM: RAM read latency is 1 cycle. A one-entry output register plus prefetch sustains 1 word/cycle while i_ready is held high.
  - o_data/o_valid hold steady while o_valid & !i_ready.
  - o_last = 1 on the word at addr len-1. On its handshake: mark the bank empty, toggle rbank, go to R_IDLE.
- Latency: o_valid rises 2 cycles after the cycle of the last write handshake of a frame, when the read side is idle.
- Bank reuse: a bank freed by the o_last handshake in cycle t can be targeted by the writer (W_IDLE check) from cycle t+1.
- Both banks full: o_ready stays low. No data lost, no overwrite.
- Frames exit in write order: bank 0, 1, 0, 1, ...
- o_full_cnt updates on the cycle after the full or empty event. A simultaneous fill and drain leaves it unchanged.
- i_len changes during W_FILL are ignored.
- o_err clears only on reset.
- reset_n asserted mid-frame: partial frame discarded, all state returns to reset values immediately.

Optional Feature:
- Macro: IMBUF_FLIP_EN.
- When defined:
  - Adds input port i_flip (1 bit), latched together with the length at the W_IDLE→W_FILL transition and stored per bank.
  - A bank with flip = 1 is read out in reverse: addr len-1 down to 0. o_last is asserted on addr 0.
- When undefined: no i_flip port; readout is always ascending.

Test Plan:
- Single frame: i_len=5, write 0x11..0x15 back-to-back, i_ready=1 → o_data 0x11..0x15 on consecutive cycles; o_last with 0x15; o_valid first high 2 cycles after the 0x15 write.
- Overlap: write frame A (len 4) then frame B (len 4) immediately, i_ready=1 → B accepted while A streams; output A0..A3 then B0..B3; o_ready never low for more than 2 cycles between frames.
- Backpressure/full: i_ready=0, write three len-3 frames → first two accepted, o_full_cnt=2, o_ready=0. Raise i_ready → frame 1 out, then the third write accepted.
- Length bounds: i_len=0 → o_err=1, no o_ready. i_len=N+10 → o_err=1, exactly N words accepted and N words read with o_last on word N-1.
- Stall stability: i_ready toggled 1,0,0,1 mid-frame → o_data held during stall, no word dropped or duplicated.
- Reset mid-frame: reset_n low after 2 of 5 words → outputs 0, o_full_cnt=0. A new len-2 frame afterwards reads back correctly. With IMBUF_FLIP_EN and i_flip=1, len 3 of 0xA,0xB,0xC → out 0xC,0xB,0xA, o_last on 0xA.
